cam_soc_from_sw_port: RTL

//  Avalon-MM slave PIO for the software->hardware direction of the cam_soc link.

---
 rtl/cam_soc_pio_pkg.sv | 26 ++
 rtl/cam_soc_cmd_fifo.sv | 57 +++++
 rtl/cam_soc_from_sw_port.sv | 102 ++++++++++
 3 files changed

// File: rtl/cam_soc_pio_pkg.sv
// Shared register map, STATUS bit layout and sizing helper for the cam_soc sw->hw PIO.
package cam_soc_pio_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_PUSH   = 3'd2;
  localparam logic [2:0] REG_OUTSET = 3'd4;
  localparam logic [2:0] REG_OUTCLR = 3'd5;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_COUNT_W   = 5;

  // Pointer width for a power-of-two depth; count needs one extra bit.
  function automatic int fifo_aw(input int depth);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cam_soc_cmd_fifo.sv
// Sync command FIFO: push visible at head one cycle later; pop when head consumed.
// A push into a full FIFO is taken only if a pop frees a slot the same cycle.
module cam_soc_cmd_fifo
  import cam_soc_pio_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = fifo_aw(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = count_q;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage is cleared on reset too, so nothing from a flushed run can reappear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cam_soc_from_sw_port.sv
// Avalon-MM PIO, sw->hw: static out_port plus command FIFO; readdata latency 1.
// Hardware backpressures via cmd_ready; pushes into a full FIFO drop and set sticky overflow.
module cam_soc_from_sw_port
  import cam_soc_pio_pkg::*;
#(
  parameter int          DATA_WIDTH  = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready
);

  localparam int CNT_W = fifo_aw(FIFO_DEPTH) + 1;

  logic                  write;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_count;
  logic                  overflow;
  logic                  ovf_set;
  logic                  ovf_clr;
  logic [31:0]           rd_mux;
  logic                  unused_wdata;

  assign write        = chipselect & ~write_n;
  assign wdata        = writedata[DATA_WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign push         = write && (address == REG_PUSH);
  assign pop          = cmd_valid & cmd_ready;
  assign cmd_valid    = ~fifo_empty;

  cam_soc_cmd_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(wdata),
    .pop      (pop),
    .head     (cmd_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE[DATA_WIDTH-1:0];
    end else if (write) begin
      case (address)
        REG_DATA:   out_port <= wdata;
        REG_OUTSET: out_port <= out_port | wdata;
        REG_OUTCLR: out_port <= out_port & ~wdata;
        default:    out_port <= out_port;
      endcase
    end
  end

  // A drop in the same cycle as a software clear must stay visible, so set wins.
  assign ovf_set = push & fifo_full & ~pop;
  assign ovf_clr = write && (address == REG_STATUS) && writedata[STATUS_OVF_BIT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      REG_DATA: rd_mux[DATA_WIDTH-1:0] = out_port;
      REG_STATUS: begin
        rd_mux[STATUS_EMPTY_BIT]             = fifo_empty;
        rd_mux[STATUS_FULL_BIT]              = fifo_full;
        rd_mux[STATUS_OVF_BIT]               = overflow;
        rd_mux[STATUS_COUNT_LSB +: CNT_W]    = fifo_count;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

endmodule
